// File: rtl/cmp_stat_tracker_if.sv
// Sample/statistics bundle between the comparator stage and cmp_stat_tracker.
// master drives samples and clear; slave returns the registered statistics.
interface cmp_stat_tracker_if #(
    parameter int SIZE  = 5,
    parameter int CNT_W = 8
);
    logic             clear;
    logic             in_valid;
    logic [SIZE-1:0]  A;
    logic [SIZE-1:0]  B;
    logic             aequalsb;
    logic             agreaterb;
    logic             alesserb;

    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [SIZE-1:0]  max_a;
    logic [CNT_W-1:0] run_cnt;
    logic             streak;
    logic [1:0]       streak_dir;
    logic             sat;
    logic             out_valid;

    modport master (
        output clear, in_valid, A, B, aequalsb, agreaterb, alesserb,
        input  eq_cnt, gt_cnt, lt_cnt, err_cnt, max_a, run_cnt,
               streak, streak_dir, sat, out_valid
    );

    modport slave (
        input  clear, in_valid, A, B, aequalsb, agreaterb, alesserb,
        output eq_cnt, gt_cnt, lt_cnt, err_cnt, max_a, run_cnt,
               streak, streak_dir, sat, out_valid
    );
endinterface

// File: rtl/cmp_stat_tracker.sv
// Saturating outcome statistics, run detection and illegal-flag counting for comparator results.
// Latency: one cycle, sample at edge N is visible on all outputs after edge N with out_valid pulsed.
// Backpressure: none, one sample accepted every cycle; clear wins over a same-cycle sample.
module cmp_stat_tracker #(
    parameter int SIZE    = 5,
    parameter int CNT_W   = 8,
    parameter int RUN_LEN = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    cmp_stat_tracker_if.slave  st
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SAT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] RUN_THR = CNT_W'(RUN_LEN);
    localparam logic [1:0]       DIR_EQ  = 2'b00;
    localparam logic [1:0]       DIR_GT  = 2'b01;
    localparam logic [1:0]       DIR_LT  = 2'b10;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] eq_cnt_q,    eq_cnt_d;
    logic [CNT_W-1:0] gt_cnt_q,    gt_cnt_d;
    logic [CNT_W-1:0] lt_cnt_q,    lt_cnt_d;
    logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
    logic [CNT_W-1:0] run_cnt_q,   run_cnt_d;
    logic [SIZE-1:0]  max_a_q,     max_a_d;
    logic             have_max_q,  have_max_d;
    logic [1:0]       dir_q,       dir_d;
    logic             streak_q,    streak_d;
    logic             sat_q,       sat_d;
    logic             out_valid_q, out_valid_d;

    logic             legal;
    logic [1:0]       dir_new;
    logic             cnt_full;

    // B carries no information beyond the flags; kept on the bundle for the debug view.
    logic unused_b;
    assign unused_b = ^st.B;

    // One-hot of three: odd number of flags set, but not all three.
    assign legal   = (st.aequalsb ^ st.agreaterb ^ st.alesserb)
                   & ~(st.aequalsb & st.agreaterb & st.alesserb);
    assign dir_new = st.agreaterb ? DIR_GT : (st.alesserb ? DIR_LT : DIR_EQ);

    always_comb begin
        state_d     = state_q;
        eq_cnt_d    = eq_cnt_q;
        gt_cnt_d    = gt_cnt_q;
        lt_cnt_d    = lt_cnt_q;
        err_cnt_d   = err_cnt_q;
        run_cnt_d   = run_cnt_q;
        max_a_d     = max_a_q;
        have_max_d  = have_max_q;
        dir_d       = dir_q;
        out_valid_d = 1'b0;
        cnt_full    = 1'b0;

        if (st.clear) begin
            state_d    = S_IDLE;
            eq_cnt_d   = '0;
            gt_cnt_d   = '0;
            lt_cnt_d   = '0;
            err_cnt_d  = '0;
            run_cnt_d  = '0;
            max_a_d    = '0;
            have_max_d = 1'b0;
            dir_d      = DIR_EQ;
        end else if (st.in_valid) begin
            out_valid_d = 1'b1;
            if (legal) begin
                case (dir_new)
                    DIR_GT:  gt_cnt_d = sat_inc(gt_cnt_q);
                    DIR_LT:  lt_cnt_d = sat_inc(lt_cnt_q);
                    default: eq_cnt_d = sat_inc(eq_cnt_q);
                endcase
                if (!have_max_q || (st.A > max_a_q)) begin
                    max_a_d = st.A;
                end
                have_max_d = 1'b1;
                // A zero run length means the previous legal outcome is stale (reset/illegal).
                if ((run_cnt_q != '0) && (dir_new == dir_q)) begin
                    run_cnt_d = sat_inc(run_cnt_q);
                end else begin
                    run_cnt_d = CNT_ONE;
                    dir_d     = dir_new;
                end
            end else begin
                err_cnt_d = sat_inc(err_cnt_q);
                run_cnt_d = '0;
            end

            cnt_full = (eq_cnt_d == CNT_MAX) || (gt_cnt_d == CNT_MAX) ||
                       (lt_cnt_d == CNT_MAX) || (err_cnt_d == CNT_MAX);

            case (state_q)
                S_IDLE:  state_d = cnt_full ? S_SAT : S_RUN;
                S_RUN:   state_d = cnt_full ? S_SAT : S_RUN;
                default: state_d = S_SAT;
            endcase
        end

        streak_d = (run_cnt_d >= RUN_THR);
        sat_d    = (state_d == S_SAT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            eq_cnt_q    <= '0;
            gt_cnt_q    <= '0;
            lt_cnt_q    <= '0;
            err_cnt_q   <= '0;
            run_cnt_q   <= '0;
            max_a_q     <= '0;
            have_max_q  <= 1'b0;
            dir_q       <= DIR_EQ;
            streak_q    <= 1'b0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            eq_cnt_q    <= eq_cnt_d;
            gt_cnt_q    <= gt_cnt_d;
            lt_cnt_q    <= lt_cnt_d;
            err_cnt_q   <= err_cnt_d;
            run_cnt_q   <= run_cnt_d;
            max_a_q     <= max_a_d;
            have_max_q  <= have_max_d;
            dir_q       <= dir_d;
            streak_q    <= streak_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign st.eq_cnt     = eq_cnt_q;
    assign st.gt_cnt     = gt_cnt_q;
    assign st.lt_cnt     = lt_cnt_q;
    assign st.err_cnt    = err_cnt_q;
    assign st.max_a      = max_a_q;
    assign st.run_cnt    = run_cnt_q;
    assign st.streak     = streak_q;
    assign st.streak_dir = dir_q;
    assign st.sat        = sat_q;
    assign st.out_valid  = out_valid_q;
endmodule

// File: tb/tb_cmp_stat_tracker.sv
// Directed bench for cmp_stat_tracker: an 8-bit-counter instance for function,
// and a 4-bit-counter instance for the saturation boundary.
module tb_cmp_stat_tracker;
    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;
    int ov_cnt;
    int ov_base;

    cmp_stat_tracker_if #(.SIZE(5), .CNT_W(8)) b8 ();
    cmp_stat_tracker_if #(.SIZE(5), .CNT_W(4)) b4 ();

    cmp_stat_tracker #(.SIZE(5), .CNT_W(8), .RUN_LEN(3)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .st    (b8)
    );

    cmp_stat_tracker #(.SIZE(5), .CNT_W(4), .RUN_LEN(3)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .st    (b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ov_cnt = 0;
    always @(negedge clk) if (b8.out_valid === 1'b1) ov_cnt = ov_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // f = {aequalsb, agreaterb, alesserb}; returns 1 time unit after the sampling edge.
    task automatic drv8(input logic v, input logic c, input logic [4:0] a,
                        input logic [4:0] b, input logic [2:0] f);
        b8.in_valid = v;
        b8.clear    = c;
        b8.A        = a;
        b8.B        = b;
        {b8.aequalsb, b8.agreaterb, b8.alesserb} = f;
        @(posedge clk);
        #1;
    endtask

    task automatic drv4(input logic v, input logic c, input logic [4:0] a,
                        input logic [4:0] b, input logic [2:0] f);
        b4.in_valid = v;
        b4.clear    = c;
        b4.A        = a;
        b4.B        = b;
        {b4.aequalsb, b4.agreaterb, b4.alesserb} = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        b8.in_valid = 1'b0; b8.clear = 1'b0; b8.A = '0; b8.B = '0;
        b8.aequalsb = 1'b0; b8.agreaterb = 1'b0; b8.alesserb = 1'b0;
        b4.in_valid = 1'b0; b4.clear = 1'b0; b4.A = '0; b4.B = '0;
        b4.aequalsb = 1'b0; b4.agreaterb = 1'b0; b4.alesserb = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_eq",     b8.eq_cnt,     0);
        chk("rst_err",    b8.err_cnt,    0);
        chk("rst_run",    b8.run_cnt,    0);
        chk("rst_max",    b8.max_a,      0);
        chk("rst_sat",    b8.sat,        0);
        chk("rst_ovld",   b8.out_valid,  0);
        chk("rst_dir",    b8.streak_dir, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Four mixed legal samples.
        ov_base = ov_cnt;
        drv8(1, 0, 5'd3, 5'd3, 3'b100);
        chk("t1_first_ovld", b8.out_valid, 1);
        chk("t1_first_eq",   b8.eq_cnt,    1);
        drv8(1, 0, 5'd7, 5'd2, 3'b010);
        drv8(1, 0, 5'd1, 5'd9, 3'b001);
        drv8(1, 0, 5'd5, 5'd5, 3'b100);
        chk("t1_eq",     b8.eq_cnt,     2);
        chk("t1_gt",     b8.gt_cnt,     1);
        chk("t1_lt",     b8.lt_cnt,     1);
        chk("t1_err",    b8.err_cnt,    0);
        chk("t1_max",    b8.max_a,      7);
        chk("t1_run",    b8.run_cnt,    1);
        chk("t1_dir",    b8.streak_dir, 0);
        drv8(0, 0, 5'd0, 5'd0, 3'b000);
        chk("t1_idle_ovld", b8.out_valid, 0);
        chk("t1_pulses",    ov_cnt - ov_base, 4);

        // Three gt in a row build a streak; an lt breaks it.
        drv8(1, 0, 5'd9, 5'd1, 3'b010);
        chk("t2_run1",    b8.run_cnt, 1);
        chk("t2_dir1",    b8.streak_dir, 1);
        drv8(1, 0, 5'd9, 5'd1, 3'b010);
        chk("t2_run2",    b8.run_cnt, 2);
        chk("t2_streak2", b8.streak,  0);
        drv8(1, 0, 5'd9, 5'd1, 3'b010);
        chk("t2_run3",    b8.run_cnt, 3);
        chk("t2_streak3", b8.streak,  1);
        chk("t2_ovld3",   b8.out_valid, 1);
        chk("t2_dir3",    b8.streak_dir, 1);
        chk("t2_gt",      b8.gt_cnt,  4);
        drv8(1, 0, 5'd2, 5'd9, 3'b001);
        chk("t2_run_lt",    b8.run_cnt, 1);
        chk("t2_streak_lt", b8.streak,  0);
        chk("t2_dir_lt",    b8.streak_dir, 2);
        chk("t2_max",       b8.max_a, 9);

        // Illegal flag patterns, then flags without in_valid.
        drv8(1, 0, 5'd4, 5'd4, 3'b000);
        drv8(1, 0, 5'd20, 5'd3, 3'b110);
        chk("t3_err",  b8.err_cnt, 2);
        chk("t3_eq",   b8.eq_cnt,  2);
        chk("t3_gt",   b8.gt_cnt,  4);
        chk("t3_lt",   b8.lt_cnt,  2);
        chk("t3_run",  b8.run_cnt, 0);
        chk("t3_strk", b8.streak,  0);
        chk("t3_dir",  b8.streak_dir, 2);
        chk("t3_max",  b8.max_a,   9);
        drv8(0, 0, 5'd31, 5'd0, 3'b010);
        chk("t3_novld_gt",   b8.gt_cnt,    4);
        chk("t3_novld_ovld", b8.out_valid, 0);
        chk("t3_novld_max",  b8.max_a,     9);

        // clear wins over a simultaneous sample.
        drv8(1, 1, 5'd30, 5'd1, 3'b010);
        chk("t4_eq",   b8.eq_cnt,  0);
        chk("t4_gt",   b8.gt_cnt,  0);
        chk("t4_lt",   b8.lt_cnt,  0);
        chk("t4_err",  b8.err_cnt, 0);
        chk("t4_max",  b8.max_a,   0);
        chk("t4_run",  b8.run_cnt, 0);
        chk("t4_dir",  b8.streak_dir, 0);
        chk("t4_ovld", b8.out_valid, 0);
        chk("t4_sat",  b8.sat,     0);
        drv8(1, 0, 5'd1, 5'd1, 3'b100);
        chk("t4_after_eq",  b8.eq_cnt, 1);
        chk("t4_after_max", b8.max_a,  1);

        // Asynchronous reset in the middle of a back-to-back gt stream.
        drv8(1, 0, 5'd6, 5'd2, 3'b010);
        drv8(1, 0, 5'd6, 5'd2, 3'b010);
        chk("t5_pre_gt",  b8.gt_cnt,  2);
        chk("t5_pre_run", b8.run_cnt, 2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_gt",   b8.gt_cnt,    0);
        chk("t5_rst_eq",   b8.eq_cnt,    0);
        chk("t5_rst_ovld", b8.out_valid, 0);
        chk("t5_rst_run",  b8.run_cnt,   0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_post_gt",   b8.gt_cnt,     1);
        chk("t5_post_run",  b8.run_cnt,    1);
        chk("t5_post_dir",  b8.streak_dir, 1);
        chk("t5_post_ovld", b8.out_valid,  1);
        drv8(0, 0, 5'd0, 5'd0, 3'b000);

        // 4-bit counters: saturation at 15.
        for (int i = 1; i <= 17; i++) begin
            drv4(1, 0, 5'd2, 5'd2, 3'b100);
            chk($sformatf("t6_eq_%0d", i),  b4.eq_cnt,  (i < 15) ? i : 15);
            chk($sformatf("t6_sat_%0d", i), b4.sat,     (i >= 15) ? 1 : 0);
            chk($sformatf("t6_run_%0d", i), b4.run_cnt, (i < 15) ? i : 15);
        end
        drv4(0, 1, 5'd0, 5'd0, 3'b000);
        chk("t6_clr_sat", b4.sat,    0);
        chk("t6_clr_eq",  b4.eq_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
